// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared definitions for the LFSR random-word arbiter.
//   - arb_state_t : arbiter FSM state encoding (WARMUP, IDLE, GEN, DELIVER)
//   - TAPS_W*     : known-good feedback tap masks for common widths
//   - default_taps: picks a tap mask for a given LFSR width
//   - next_lfsr   : one Fibonacci shift step (shift left, feedback into bit 0)
package lfsr_pkg;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    IDLE    = 2'd1,
    GEN     = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Widths without a tabulated polynomial fall back to the MSB alone,
  // which is a plain rotate; such instances must override TAPS.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      4:       return 32'(TAPS_W4);
      8:       return 32'(TAPS_W8);
      16:      return 32'(TAPS_W16);
      32:      return TAPS_W32;
      default: return 32'd1 << (width - 1);
    endcase
  endfunction

  // Works on a 32-bit container so one function serves every width;
  // bits at and above 'width' are forced to zero.
  function automatic logic [31:0] next_lfsr(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_if.sv
// lfsr_rand_arbiter_if
//   Bundle between the random-number consumers and the arbiter.
//   Consumer side (master) drives: i_seed_load, i_seed, i_req, i_ack.
//   Arbiter side (slave) drives:   o_grant, o_data, o_valid, o_ready.
interface lfsr_rand_arbiter_if #(
  parameter int NO_OF_REQ  = 4,
  parameter int LFSR_WIDTH = 16,
  parameter int WORD_WIDTH = 8
) ();

  logic                  i_seed_load;
  logic [LFSR_WIDTH-1:0] i_seed;
  logic [NO_OF_REQ-1:0]  i_req;
  logic                  i_ack;
  logic [NO_OF_REQ-1:0]  o_grant;
  logic [WORD_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_ready;

  modport master (
    output i_seed_load, i_seed, i_req, i_ack,
    input  o_grant, o_data, o_valid, o_ready
  );

  modport slave (
    input  i_seed_load, i_seed, i_req, i_ack,
    output o_grant, o_data, o_valid, o_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. The search starts just above 'last'
//   and wraps to index 0; the pointer register lives in the parent.
//   Ports:
//     req   - request vector
//     last  - index of the most recently granted requester
//     grant - one-hot grant, all zero when req is zero
module rr_arbiter #(
  parameter int NO_OF_REQ = 4
) (
  input  logic [NO_OF_REQ-1:0]         req,
  input  logic [$clog2(NO_OF_REQ)-1:0] last,
  output logic [NO_OF_REQ-1:0]         grant
);

  logic [NO_OF_REQ-1:0] upper_mask;
  logic [NO_OF_REQ-1:0] req_upper;
  logic [NO_OF_REQ-1:0] pick;

  // Requesters strictly above 'last' have priority over the wrapped ones.
  genvar gi;
  generate
    for (gi = 0; gi < NO_OF_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (gi > int'(last));
    end
  endgenerate

  assign req_upper = req & upper_mask;
  assign pick      = (|req_upper) ? req_upper : req;
  // Isolate the lowest set bit of the chosen vector.
  assign grant     = pick & (~pick + NO_OF_REQ'(1));

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter
//   Shares one Fibonacci LFSR among NO_OF_REQ requesters. After a seed load
//   the LFSR free-runs WARMUP_CYCLES steps, then each round-robin grant
//   receives a fresh WORD_WIDTH-bit word shifted out MSB-first, held until
//   the requester acks it.
//   Ports:
//     i_clk, i_rst - clock, synchronous active-high reset
//     bus (slave)  - seed load/value, request/ack in; grant/data/valid/ready out
module lfsr_rand_arbiter
  import lfsr_pkg::*;
#(
  parameter int                    NO_OF_REQ     = 4,
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = LFSR_WIDTH'(default_taps(LFSR_WIDTH)),
  parameter int                    WORD_WIDTH    = 8,
  parameter int                    WARMUP_CYCLES = 16,
  parameter logic [LFSR_WIDTH-1:0] RESET_SEED    = LFSR_WIDTH'(1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  lfsr_rand_arbiter_if.slave  bus
);

  localparam int IDX_W  = $clog2(NO_OF_REQ);
  localparam int WARM_W = $clog2(WARMUP_CYCLES + 2);
  localparam int BIT_W  = $clog2(WORD_WIDTH + 1);

  localparam logic [WARM_W-1:0] WARM_LAST =
    WARM_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

  // An all-zero state would lock the LFSR, so zero seeds become 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_INIT =
    (RESET_SEED == '0) ? LFSR_WIDTH'(1) : RESET_SEED;

  arb_state_t            state_reg;
  logic [LFSR_WIDTH-1:0] lfsr_reg;
  logic [IDX_W-1:0]      rr_last_reg;
  logic [WARM_W-1:0]     warm_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic                  dropped_reg;
  logic [NO_OF_REQ-1:0]  grant_reg;
  logic [WORD_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  ready_reg;

  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [LFSR_WIDTH-1:0] seed_fixed;
  logic [WORD_WIDTH-1:0] data_shift;
  logic [NO_OF_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  out_bit;
  logic                  req_kept;

  assign out_bit    = lfsr_reg[LFSR_WIDTH-1];
  assign lfsr_next  = LFSR_WIDTH'(next_lfsr(32'(lfsr_reg), 32'(TAPS), LFSR_WIDTH));
  assign seed_fixed = (bus.i_seed == '0) ? LFSR_WIDTH'(1) : bus.i_seed;
  // Is the currently granted requester still asking?
  assign req_kept   = |(bus.i_req & grant_reg);

  generate
    if (WORD_WIDTH == 1) begin : g_word1
      assign data_shift = out_bit;
    end else begin : g_wordn
      assign data_shift = {data_reg[WORD_WIDTH-2:0], out_bit};
    end
  endgenerate

  rr_arbiter #(
    .NO_OF_REQ (NO_OF_REQ)
  ) u_rr_arbiter (
    .req   (bus.i_req),
    .last  (rr_last_reg),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < NO_OF_REQ; k++) begin
      if (arb_grant[k]) arb_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= WARMUP;
      lfsr_reg     <= SEED_INIT;
      rr_last_reg  <= IDX_W'(NO_OF_REQ - 1);
      warm_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      dropped_reg  <= 1'b0;
      grant_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ready_reg    <= 1'b0;
    end else if (bus.i_seed_load) begin
      // Reseed aborts any word in flight; rr_last keeps fairness across it.
      state_reg    <= WARMUP;
      lfsr_reg     <= seed_fixed;
      warm_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      dropped_reg  <= 1'b0;
      grant_reg    <= '0;
      valid_reg    <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        WARMUP: begin
          if (WARMUP_CYCLES == 0) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            lfsr_reg <= lfsr_next;
            if (warm_cnt_reg == WARM_LAST) begin
              warm_cnt_reg <= '0;
              state_reg    <= IDLE;
              ready_reg    <= 1'b1;
            end else begin
              warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
            end
          end
        end

        IDLE: begin
          if (|bus.i_req) begin
            grant_reg   <= arb_grant;
            rr_last_reg <= arb_idx;
            bit_cnt_reg <= '0;
            dropped_reg <= 1'b0;
            state_reg   <= GEN;
          end
        end

        GEN: begin
          lfsr_reg <= lfsr_next;
          data_reg <= data_shift;
          if (!req_kept) dropped_reg <= 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            // A withdrawal at any point during generation discards the word,
            // but the LFSR keeps the steps it took.
            if (dropped_reg || !req_kept) begin
              grant_reg <= '0;
              state_reg <= IDLE;
            end else begin
              valid_reg <= 1'b1;
              state_reg <= DELIVER;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end
        end

        DELIVER: begin
          if (bus.i_ack || !req_kept) begin
            valid_reg <= 1'b0;
            grant_reg <= '0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= WARMUP;
      endcase
    end
  end

  assign bus.o_grant = grant_reg;
  assign bus.o_data  = data_reg;
  assign bus.o_valid = valid_reg;
  assign bus.o_ready = ready_reg;

endmodule
